// File: rtl/vga_capture_packer.sv
// Captures a VGA-timed RGB stream, packs pixel pairs into 64-bit words and
// presents them on a first-word-fall-through valid/ready output FIFO.
module vga_capture_packer #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        fclk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        pix_en,
    input  logic        vs_n,
    input  logic        de,
    input  logic [7:0]  red,
    input  logic [7:0]  green,
    input  logic [7:0]  blue,
    output logic [63:0] dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        frame_start,
    output logic        frame_done,
    output logic        busy,
    output logic        overflow,
    output logic        short_frame,
    output logic [15:0] frame_cnt,
    output logic [15:0] drop_cnt
);

    localparam int unsigned TOTAL = H_ACTIVE * V_ACTIVE;
    localparam int unsigned CW    = $clog2(TOTAL);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST    = CW'(TOTAL - 1);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StArmed, StCapture} state_t;

    state_t        state_q, state_d;
    logic          vs_n_q;
    logic          vs_rise, take;
    logic [CW-1:0] pix_cnt_q, pix_cnt_d;
    logic [23:0]   lo_q, lo_d;
    logic          stop_pend_q, stop_pend_d;
    logic          wr_valid_q, wr_valid_d;
    logic [63:0]   wr_data_q, wr_data_d;
    logic          frame_start_q, frame_start_d;
    logic          frame_done_q, frame_done_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic          short_q, short_d;
    logic          clr_sticky;

    logic [63:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [AW:0]   count_q, count_d, avail;
    logic          dout_valid_q, valid_d;
    logic          pop, push, drop;
    logic          overflow_q;
    logic [15:0]   drop_cnt_q;

    assign vs_rise = pix_en & vs_n & ~vs_n_q;
    assign take    = pix_en & de;

    always_comb begin
        state_d       = state_q;
        pix_cnt_d     = pix_cnt_q;
        lo_d          = lo_q;
        stop_pend_d   = stop_pend_q;
        wr_valid_d    = 1'b0;
        wr_data_d     = wr_data_q;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        short_d       = short_q;
        clr_sticky    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StArmed;
                    clr_sticky = 1'b1;
                    short_d    = 1'b0;
                end
            end
            StArmed: begin
                if (stop) begin
                    state_d     = StIdle;
                    stop_pend_d = 1'b0;
                end else if (vs_rise) begin
                    state_d       = StCapture;
                    frame_start_d = 1'b1;
                    pix_cnt_d     = '0;
                end
            end
            StCapture: begin
                if (stop) stop_pend_d = 1'b1;
                if (vs_rise) begin
                    // Early vsync: flush any held pixel and restart the frame.
                    short_d   = 1'b1;
                    pix_cnt_d = '0;
                    if (pix_cnt_q[0]) begin
                        wr_valid_d = 1'b1;
                        wr_data_d  = {32'h0, 8'h0, lo_q};
                    end
                    if (stop || stop_pend_q) begin
                        state_d     = StIdle;
                        stop_pend_d = 1'b0;
                    end else begin
                        frame_start_d = 1'b1;
                    end
                end else if (take) begin
                    if (!pix_cnt_q[0]) begin
                        lo_d = {red, green, blue};
                    end else begin
                        wr_valid_d = 1'b1;
                        wr_data_d  = {8'h0, red, green, blue, 8'h0, lo_q};
                    end
                    if (pix_cnt_q == LAST) begin
                        frame_done_d = 1'b1;
                        frame_cnt_d  = frame_cnt_q + 16'd1;
                        pix_cnt_d    = '0;
                        if (stop || stop_pend_q) begin
                            state_d     = StIdle;
                            stop_pend_d = 1'b0;
                        end else begin
                            state_d = StArmed;
                        end
                    end else begin
                        pix_cnt_d = pix_cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            vs_n_q        <= 1'b1;
            pix_cnt_q     <= '0;
            lo_q          <= '0;
            stop_pend_q   <= 1'b0;
            wr_valid_q    <= 1'b0;
            wr_data_q     <= '0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_cnt_q   <= '0;
            short_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            if (pix_en) vs_n_q <= vs_n;
            pix_cnt_q     <= pix_cnt_d;
            lo_q          <= lo_d;
            stop_pend_q   <= stop_pend_d;
            wr_valid_q    <= wr_valid_d;
            wr_data_q     <= wr_data_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            frame_cnt_q   <= frame_cnt_d;
            short_q       <= short_d;
        end
    end

    // dout_valid follows the stored count one cycle late, giving FWFT its extra cycle.
    always_comb begin
        pop     = dout_valid_q & dout_ready;
        push    = wr_valid_q & ((count_q < DEPTH_C) | pop);
        drop    = wr_valid_q & ~push;
        count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        avail   = count_q - {{AW{1'b0}}, pop};
        valid_d = (avail != '0);
    end

    always_ff @(posedge fclk) begin
        if (push) mem[wr_ptr_q] <= wr_data_q;
    end

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q      <= count_d;
            dout_valid_q <= valid_d;
            if (clr_sticky) overflow_q <= 1'b0;
            if (drop) overflow_q <= 1'b1;
            if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign dout        = dout_valid_q ? mem[rd_ptr_q] : 64'h0;
    assign dout_valid  = dout_valid_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign busy        = (state_q != StIdle);
    assign overflow    = overflow_q;
    assign short_frame = short_q;
    assign frame_cnt   = frame_cnt_q;
    assign drop_cnt    = drop_cnt_q;

endmodule
